// File: rtl/tm1638_pkg.sv
// TM1638 command bytes, frame byte positions and sequencer states.
// Shared by the frame sequencer and anything that decodes its traffic.
package tm1638_pkg;

    localparam logic [7:0] CMD_DATA_WR  = 8'h40;
    localparam logic [7:0] CMD_DATA_RD  = 8'h42;
    localparam logic [7:0] CMD_ADDR0    = 8'hC0;
    localparam logic [7:0] CMD_DISP_OFF = 8'h80;
    localparam logic [7:0] CMD_DISP_ON  = 8'h88;

    localparam logic [4:0] IDX_P0     = 5'd0;
    localparam logic [4:0] IDX_ADDR   = 5'd1;
    localparam logic [4:0] IDX_P1_END = 5'd17;
    localparam logic [4:0] IDX_P2     = 5'd18;
    localparam logic [4:0] IDX_P3_CMD = 5'd19;
    localparam logic [4:0] IDX_RD0    = 5'd20;
    localparam logic [4:0] IDX_LAST   = 5'd23;

    typedef enum logic [3:0] {
        IDLE,
        SNAP,
        STB_LO,
        ISSUE,
        ARM,
        XFER,
        NEXT,
        STB_HI,
        GAP
    } state_t;

    function automatic logic [7:0] led_byte(input logic on);
        return on ? 8'h01 : 8'h00;
    endfunction

    function automatic logic [7:0] disp_byte(
        input logic       on,
        input logic [2:0] level
    );
        return on ? (CMD_DISP_ON | {5'd0, level}) : CMD_DISP_OFF;
    endfunction

endpackage

// File: rtl/tm1638_frame_seq.sv
// TM1638 frame sequencer: refreshes 8 digits, 8 LEDs and brightness,
// then reads the key matrix, driving an external byte-transfer engine.
module tm1638_frame_seq
    import tm1638_pkg::*;
#(
    parameter int clk_mhz = 27,
    parameter int gap_us  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [63:0] digits,
    input  logic [7:0]  leds,
    input  logic [2:0]  brightness,
    input  logic        display_on,
    output logic [7:0]  keys,
    output logic        frame_done,
    output logic        stb,
    output logic        dio_oe,
    output logic        sio_latch,
    output logic [7:0]  sio_data,
    output logic        sio_rw,
    input  logic        sio_busy,
    input  logic [7:0]  sio_rdata
);

    localparam int GAP_RAW = clk_mhz * gap_us;
    localparam int GAP_CYC = (GAP_RAW < 1) ? 1 : GAP_RAW;
    localparam int GW      = $clog2(GAP_CYC + 1);

    state_t      state;
    logic [4:0]  idx;
    logic [GW-1:0] gcnt;
    logic        last;
    logic        armed;

    logic [63:0] digits_q;
    logic [7:0]  leds_q;
    logic [2:0]  bright_q;
    logic        disp_q;
    logic [7:0]  rd_q [4];

    logic [7:0]  tx_byte;
    logic        tx_rw;
    logic [3:0]  pos;
    logic [1:0]  rk;
    logic [7:0]  next_keys;

    assign rk = 2'(idx - IDX_RD0);

    // Byte to send (and direction) for the current frame position.
    always_comb begin
        tx_byte = 8'h00;
        tx_rw   = 1'b0;
        pos     = 4'(idx - 5'd2);
        if (idx == IDX_P0) begin
            tx_byte = CMD_DATA_WR;
        end else if (idx == IDX_ADDR) begin
            tx_byte = CMD_ADDR0;
        end else if (idx <= IDX_P1_END) begin
            if (pos[0])
                tx_byte = led_byte(leds_q[pos[3:1]]);
            else
                tx_byte = digits_q[{pos[3:1], 3'b000} +: 8];
        end else if (idx == IDX_P2) begin
            tx_byte = disp_byte(disp_q, bright_q);
        end else if (idx == IDX_P3_CMD) begin
            tx_byte = CMD_DATA_RD;
        end else begin
            tx_rw = 1'b1;
        end
    end

    // Key byte k carries key k in bit 0 and key k+4 in bit 4.
    always_comb begin
        next_keys = 8'h00;
        for (int k = 0; k < 4; k++) begin
            next_keys[k]     = rd_q[k][0];
            next_keys[k + 4] = rd_q[k][4];
        end
    end

    // Frame sequencing FSM with registered strobe and engine handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= 5'd0;
            gcnt       <= '0;
            last       <= 1'b0;
            armed      <= 1'b0;
            digits_q   <= 64'd0;
            leds_q     <= 8'd0;
            bright_q   <= 3'd0;
            disp_q     <= 1'b0;
            for (int k = 0; k < 4; k++) rd_q[k] <= 8'd0;
            keys       <= 8'd0;
            frame_done <= 1'b0;
            stb        <= 1'b1;
            dio_oe     <= 1'b0;
            sio_latch  <= 1'b0;
            sio_data   <= 8'd0;
            sio_rw     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            armed      <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (enable && armed) state <= SNAP;
                end
                SNAP: begin
                    digits_q <= digits;
                    leds_q   <= leds;
                    bright_q <= brightness;
                    disp_q   <= display_on;
                    idx      <= 5'd0;
                    last     <= 1'b0;
                    stb      <= 1'b0;
                    dio_oe   <= 1'b1;
                    state    <= STB_LO;
                end
                STB_LO: begin
                    state <= ISSUE;
                end
                ISSUE: begin
                    if (!sio_latch) begin
                        sio_data <= tx_byte;
                        sio_rw   <= tx_rw;
                        dio_oe   <= ~tx_rw;
                        if (!sio_busy) sio_latch <= 1'b1;
                    end else begin
                        sio_latch <= 1'b0;
                        state     <= ARM;
                    end
                end
                ARM: begin
                    state <= XFER;
                end
                XFER: begin
                    if (!sio_busy) begin
                        if (sio_rw) rd_q[rk] <= sio_rdata;
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (idx == IDX_LAST) begin
                        last   <= 1'b1;
                        stb    <= 1'b1;
                        dio_oe <= 1'b0;
                        state  <= STB_HI;
                    end else if (idx == IDX_P0 || idx == IDX_P1_END
                                 || idx == IDX_P2) begin
                        idx    <= idx + 5'd1;
                        stb    <= 1'b1;
                        dio_oe <= 1'b0;
                        state  <= STB_HI;
                    end else if (idx == IDX_P3_CMD) begin
                        idx   <= idx + 5'd1;
                        gcnt  <= GW'(GAP_CYC - 1);
                        state <= GAP;
                    end else begin
                        idx   <= idx + 5'd1;
                        state <= ISSUE;
                    end
                end
                STB_HI: begin
                    gcnt  <= GW'(GAP_CYC - 1);
                    state <= GAP;
                end
                GAP: begin
                    if (gcnt != '0) begin
                        gcnt <= gcnt - 1'b1;
                    end else if (!stb) begin
                        state <= ISSUE;
                    end else if (last) begin
                        keys       <= next_keys;
                        frame_done <= 1'b1;
                        idx        <= 5'd0;
                        state      <= enable ? SNAP : IDLE;
                    end else begin
                        stb    <= 1'b0;
                        dio_oe <= 1'b1;
                        state  <= STB_LO;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tm1638_frame_seq.sv
// Directed bench for the TM1638 frame sequencer with a behavioural
// byte-transfer engine and a bus monitor logging every latched byte.
module tb_tm1638_frame_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [63:0] digits = 64'd0;
    logic [7:0]  leds = 8'd0;
    logic [2:0]  brightness = 3'd0;
    logic        display_on = 1'b0;
    logic [7:0]  keys;
    logic        frame_done;
    logic        stb;
    logic        dio_oe;
    logic        sio_latch;
    logic [7:0]  sio_data;
    logic        sio_rw;
    logic        sio_busy;
    logic [7:0]  sio_rdata;

    int checks = 0;
    int errors = 0;

    tm1638_frame_seq #(.clk_mhz(27), .gap_us(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .digits     (digits),
        .leds       (leds),
        .brightness (brightness),
        .display_on (display_on),
        .keys       (keys),
        .frame_done (frame_done),
        .stb        (stb),
        .dio_oe     (dio_oe),
        .sio_latch  (sio_latch),
        .sio_data   (sio_data),
        .sio_rw     (sio_rw),
        .sio_busy   (sio_busy),
        .sio_rdata  (sio_rdata)
    );

    always #5 clk = ~clk;

    // Byte engine: busy for three cycles after each latch, key bytes in order.
    logic [7:0] rd_tbl [4];
    int rd_k;
    int busy_cnt;
    initial begin
        rd_tbl[0] = 8'h11;
        rd_tbl[1] = 8'h00;
        rd_tbl[2] = 8'h10;
        rd_tbl[3] = 8'h01;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sio_busy  <= 1'b0;
            sio_rdata <= 8'h00;
            busy_cnt  <= 0;
            rd_k      <= 0;
        end else if (sio_latch) begin
            sio_busy <= 1'b1;
            busy_cnt <= 3;
            if (sio_rw) begin
                sio_rdata <= rd_tbl[rd_k];
                rd_k      <= (rd_k + 1) % 4;
            end
        end else if (sio_busy) begin
            if (busy_cnt == 1) sio_busy <= 1'b0;
            busy_cnt <= busy_cnt - 1;
        end
    end

    // Monitor: byte log, packet numbering, pulse and gap measurements.
    logic [7:0] q_data [$];
    logic       q_rw   [$];
    logic       q_oe   [$];
    logic       q_stb  [$];
    int         q_pkt  [$];
    logic mon_clr = 1'b0;
    logic prev_stb = 1'b1;
    logic prev_fd = 1'b0;
    int pkt = 0;
    int fd_cnt = 0, fd_dbl = 0;
    int hi_run = 0, hi_min = 1000;
    logic hi_valid = 1'b0;
    int c2r_ph = 0, c2r_cnt = 0, c2r_min = 1000, c2r_seen = 0;

    always @(negedge clk) begin
        if (mon_clr) begin
            q_data.delete();
            q_rw.delete();
            q_oe.delete();
            q_stb.delete();
            q_pkt.delete();
            fd_cnt = 0;
            fd_dbl = 0;
            hi_run = 0;
            hi_min = 1000;
            hi_valid = 1'b0;
            c2r_ph = 0;
            c2r_cnt = 0;
            c2r_min = 1000;
            c2r_seen = 0;
        end else begin
            if (!stb && prev_stb) pkt = pkt + 1;
            if (sio_latch) begin
                q_data.push_back(sio_data);
                q_rw.push_back(sio_rw);
                q_oe.push_back(dio_oe);
                q_stb.push_back(stb);
                q_pkt.push_back(pkt);
            end
            if (frame_done) begin
                fd_cnt = fd_cnt + 1;
                if (prev_fd) fd_dbl = fd_dbl + 1;
            end
            if (stb) begin
                if (!prev_stb) begin
                    hi_valid = 1'b1;
                    hi_run = 0;
                end
                hi_run = hi_run + 1;
            end else if (prev_stb && hi_valid) begin
                if (hi_run < hi_min) hi_min = hi_run;
                hi_valid = 1'b0;
            end
            case (c2r_ph)
                0: if (sio_latch && !sio_rw && sio_data == 8'h42) c2r_ph = 1;
                1: if (sio_busy) c2r_ph = 2;
                2: if (!sio_busy) begin c2r_ph = 3; c2r_cnt = 1; end
                default: begin
                    if (sio_latch) begin
                        if (c2r_cnt < c2r_min) c2r_min = c2r_cnt;
                        c2r_seen = c2r_seen + 1;
                        c2r_ph = 0;
                    end else begin
                        c2r_cnt = c2r_cnt + 1;
                    end
                end
            endcase
        end
        prev_stb = stb;
        prev_fd = frame_done;
    end

    task automatic clear_log();
        @(negedge clk);
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic wait_first_latch(output bit to);
        to = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (q_data.size() > 0) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_done(input int n, output bit to);
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (fd_cnt >= n) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic set_base();
        digits = 64'h0706050403020100;
        leds = 8'hA5;
        brightness = 3'd5;
        display_on = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        enable = 1'b0;
        set_base();
        repeat (3) @(negedge clk);
        checks++;
        if (stb !== 1'b1) begin
            errors++; $display("FAIL rst_stb got %b want 1", stb);
        end
        checks++;
        if (dio_oe !== 1'b0) begin
            errors++; $display("FAIL rst_oe got %b want 0", dio_oe);
        end
        checks++;
        if (sio_latch !== 1'b0 || sio_rw !== 1'b0 || sio_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_sio got latch %b rw %b data %h want 0 0 00",
                     sio_latch, sio_rw, sio_data);
        end
        checks++;
        if (keys !== 8'h00 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_keys got %h fd %b want 00 0", keys, frame_done);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (stb !== 1'b1 || q_data.size() != 0) begin
            errors++;
            $display("FAIL idle_hold got stb %b bytes %0d want 1 0",
                     stb, q_data.size());
        end
    endtask

    task automatic test_frame();
        logic [7:0] exp_p1 [17];
        bit to;
        int bad;
        exp_p1 = '{8'hC0, 8'h00, 8'h01, 8'h01, 8'h00, 8'h02, 8'h01,
                   8'h03, 8'h00, 8'h04, 8'h00, 8'h05, 8'h01, 8'h06,
                   8'h00, 8'h07, 8'h01};
        set_base();
        clear_log();
        enable = 1'b1;
        wait_first_latch(to);
        enable = 1'b0;
        checks++;
        if (to) begin
            errors++; $display("FAIL frame_start got timeout want latch");
        end
        wait_done(1, to);
        repeat (5) @(negedge clk);
        checks++;
        if (to || q_data.size() != 24) begin
            errors++;
            $display("FAIL frame_len got %0d bytes to %b want 24", q_data.size(), to);
        end
        if (q_data.size() == 24) begin
            checks++;
            if (q_data[0] !== 8'h40) begin
                errors++; $display("FAIL p0 got %h want 40", q_data[0]);
            end
            for (int i = 0; i < 17; i++) begin
                checks++;
                if (q_data[i + 1] !== exp_p1[i]) begin
                    errors++;
                    $display("FAIL p1_byte%0d got %h want %h", i, q_data[i + 1], exp_p1[i]);
                end
            end
            checks++;
            if (q_data[18] !== 8'h8D) begin
                errors++; $display("FAIL p2 got %h want 8d", q_data[18]);
            end
            checks++;
            if (q_data[19] !== 8'h42) begin
                errors++; $display("FAIL p3_cmd got %h want 42", q_data[19]);
            end
            bad = 0;
            for (int i = 0; i < 24; i++) begin
                if (q_stb[i] !== 1'b0) bad++;
                if (i < 20 && (q_rw[i] !== 1'b0 || q_oe[i] !== 1'b1)) bad++;
                if (i >= 20 && (q_rw[i] !== 1'b1 || q_oe[i] !== 1'b0)) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL dir_stb got %0d bad bytes want 0", bad);
            end
            bad = 0;
            for (int i = 2; i < 18; i++) if (q_pkt[i] != q_pkt[1]) bad++;
            for (int i = 20; i < 24; i++) if (q_pkt[i] != q_pkt[19]) bad++;
            if (q_pkt[1] != q_pkt[0] + 1) bad++;
            if (q_pkt[18] != q_pkt[0] + 2) bad++;
            if (q_pkt[19] != q_pkt[0] + 3) bad++;
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL packets got %0d bad splits want 0", bad);
            end
        end
        checks++;
        if (keys !== 8'h59) begin
            errors++; $display("FAIL keys got %h want 59", keys);
        end
        checks++;
        if (fd_cnt != 1 || fd_dbl != 0) begin
            errors++;
            $display("FAIL frame_done got %0d pulses %0d long want 1 0", fd_cnt, fd_dbl);
        end
        checks++;
        if (stb !== 1'b1 || dio_oe !== 1'b0) begin
            errors++; $display("FAIL end_idle got stb %b oe %b want 1 0", stb, dio_oe);
        end
    endtask

    task automatic test_snapshot_dim();
        bit to;
        set_base();
        display_on = 1'b0;
        clear_log();
        enable = 1'b1;
        wait_first_latch(to);
        enable = 1'b0;
        digits = 64'hFFFF_FFFF_FFFF_FFFF;
        leds = 8'h00;
        brightness = 3'd7;
        display_on = 1'b1;
        wait_done(1, to);
        checks++;
        if (to || q_data.size() != 24) begin
            errors++;
            $display("FAIL snap_len got %0d bytes to %b want 24", q_data.size(), to);
        end else begin
            checks++;
            if (q_data[18] !== 8'h80) begin
                errors++; $display("FAIL p2_off got %h want 80", q_data[18]);
            end
            checks++;
            if (q_data[2] !== 8'h00 || q_data[3] !== 8'h01
                || q_data[16] !== 8'h07 || q_data[17] !== 8'h01) begin
                errors++;
                $display("FAIL snapshot got %h %h %h %h want 00 01 07 01",
                         q_data[2], q_data[3], q_data[16], q_data[17]);
            end
        end
    endtask

    task automatic test_single_pulse();
        bit to;
        set_base();
        clear_log();
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wait_done(1, to);
        repeat (400) @(negedge clk);
        checks++;
        if (to || q_data.size() != 24 || fd_cnt != 1) begin
            errors++;
            $display("FAIL single got %0d bytes %0d frames want 24 1",
                     q_data.size(), fd_cnt);
        end
        checks++;
        if (stb !== 1'b1 || sio_latch !== 1'b0) begin
            errors++; $display("FAIL single_idle got stb %b latch %b want 1 0", stb, sio_latch);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        set_base();
        clear_log();
        enable = 1'b1;
        wait_done(1, to);
        enable = 1'b0;
        wait_done(2, to);
        repeat (5) @(negedge clk);
        checks++;
        if (to || q_data.size() != 48) begin
            errors++;
            $display("FAIL b2b got %0d bytes to %b want 48", q_data.size(), to);
        end else begin
            checks++;
            if (q_data[24] !== 8'h40 || q_data[25] !== 8'hC0) begin
                errors++;
                $display("FAIL b2b_restart got %h %h want 40 c0", q_data[24], q_data[25]);
            end
        end
        checks++;
        if (hi_min < 27 || hi_min == 1000) begin
            errors++; $display("FAIL stb_gap got %0d cycles want >=27", hi_min);
        end
        checks++;
        if (c2r_seen != 2 || c2r_min < 27) begin
            errors++;
            $display("FAIL cmd_rd_gap got %0d cycles seen %0d want >=27 2",
                     c2r_min, c2r_seen);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        set_base();
        clear_log();
        enable = 1'b1;
        to = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (q_data.size() >= 11) begin
                to = 1'b0;
                break;
            end
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (to || stb !== 1'b1 || sio_latch !== 1'b0 || dio_oe !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst got stb %b latch %b oe %b to %b want 1 0 0 0",
                     stb, sio_latch, dio_oe, to);
        end
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        wait_first_latch(to);
        enable = 1'b0;
        checks++;
        if (to || q_data[0] !== 8'h40) begin
            errors++; $display("FAIL restart_p0 got to %b want byte 40", to);
        end
        wait_done(1, to);
        checks++;
        if (to || q_data.size() != 24 || keys !== 8'h59) begin
            errors++;
            $display("FAIL restart_frame got %0d bytes keys %h want 24 59",
                     q_data.size(), keys);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_snapshot_dim();
        test_single_pulse();
        test_back_to_back();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
